dt1_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned words and presents them, with their PC, in the IF/ID register; the decoder takes op/funct3 from InstrD.
- Bubbles are presented as InstrD = 32'h0000_0000; the decoder maps this all-zero opcode to all-zero controls (no side effects).

---
 rtl/dt1_pkg.sv | 11 +
 rtl/dt1_fetch_if.sv | 14 +
 rtl/dt1_fetch_fifo.sv | 49 ++++
 rtl/dt1_fetch.sv | 113 +++++++++++
 tb/tb_dt1_fetch.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dt1_pkg.sv
// Shared types and constants for the dt1 instruction-fetch stage.
package dt1_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_BUBBLE = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/dt1_fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface dt1_fetch_if;
  import dt1_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/dt1_fetch_fifo.sv
// Small synchronous FIFO with clear; used for the tag queue and the response buffer.
module dt1_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/dt1_fetch.sv
// Fetch stage: owns PCF, issues credit-limited imem requests, drops wrong-path
// responses after a redirect and feeds the IF/ID register via buffer or bypass.
module dt1_fetch import dt1_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  dt1_fetch_if.master       imem,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] pcf, tag_pc;
  logic [CW-1:0]   outstanding, drop, tag_count, buf_count;
  logic [CW:0]     credit_used;
  logic            tag_full, tag_empty, buf_full, buf_empty;
  logic            accept, rsp_keep, load_en, pop_buf, bypass, push_buf, d_load;
  fetch_entry_t    rsp_entry, buf_head, d_next;

  // Credit covers words in flight plus words parked in the buffer, so the buffer cannot overflow.
  assign credit_used         = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem.imem_req_valid = reset_n && !PCSrcE && (credit_used < (CW+1)'(BUF_DEPTH));
  assign imem.imem_addr      = {pcf[XLEN-1:2], 2'b00};
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  assign rsp_keep  = imem.imem_rsp_valid && (drop == '0);
  assign rsp_entry = '{pc: tag_pc, instr: imem.imem_rsp_data};
  assign load_en   = !FlushD && !StallD;
  assign pop_buf   = load_en && !buf_empty;
  assign bypass    = load_en && buf_empty && rsp_keep;
  assign push_buf  = rsp_keep && !bypass && !PCSrcE;

  dt1_fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_tagq (
    .clk, .rst_n(reset_n),
    .push(accept), .pop(imem.imem_rsp_valid), .clear(1'b0),
    .din(imem.imem_addr), .dout(tag_pc),
    .count(tag_count), .full(tag_full), .empty(tag_empty)
  );

  dt1_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_rspbuf (
    .clk, .rst_n(reset_n),
    .push(push_buf), .pop(pop_buf), .clear(PCSrcE),
    .din(rsp_entry), .dout(buf_head),
    .count(buf_count), .full(buf_full), .empty(buf_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcf         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem.imem_rsp_valid);
      if (PCSrcE) begin
        pcf  <= {PCTargetE[XLEN-1:2], 2'b00};
        drop <= outstanding - CW'(imem.imem_rsp_valid);
      end else begin
        if (accept) pcf <= pcf + 32'd4;
        if (imem.imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  // Older buffered words always go ahead of a word arriving this cycle.
  always_comb begin
    d_next = '{pc: '0, instr: NOP_BUBBLE};
    d_load = 1'b0;
    if (!buf_empty) begin
      d_next = buf_head;
      d_load = 1'b1;
    end else if (rsp_keep) begin
      d_next = rsp_entry;
      d_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstrD   <= NOP_BUBBLE;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_BUBBLE;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= d_next.instr;
      PCD      <= d_next.pc;
      PCPlus4D <= d_load ? d_next.pc + 32'd4 : '0;
      ValidD   <= d_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push_buf && buf_full && !pop_buf));
      assert (!(accept && tag_full));
      assert (!(imem.imem_rsp_valid && tag_empty));
      assert (tag_count == outstanding);
      assert (drop <= outstanding);
    end
  end
endmodule

// File: tb/tb_dt1_fetch.sv
// Bench for dt1_fetch: directed vector table, corner sequences, then random traffic
// checked against a program-order model of the delivered instruction stream.
module tb_dt1_fetch;
  import dt1_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StallD, FlushD, PCSrcE, ValidD;
  logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;

  dt1_fetch_if mif ();

  dt1_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .imem(mif),
    .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic st, fl, ps; logic [31:0] tg;
    logic req; logic [31:0] addr;
    logic v; logic [31:0] pc, instr;
  } vec_t;

  mreq_t memq[$];
  vec_t  tbl [0:14];
  int n_chk = 0, n_fail = 0, cyc_n = 0, n_deliv = 0;
  int rdy_pct = 100, rsp_pct = 100, lat_min = 0, lat_max = 0;
  logic [31:0] exp_pc;
  logic        ed_v;
  logic [31:0] ed_pc, ed_instr, ed_p4;
  logic        prev_pend;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_v"}, 32'(ValidD), 32'd0);
    chk({name, "_instr"}, InstrD, 32'h0);
    chk({name, "_pc"}, PCD, 32'h0);
    chk({name, "_p4"}, PCPlus4D, 32'h0);
  endtask

  task automatic model_reset();
    memq.delete();
    exp_pc = 32'h0; prev_pend = 1'b0;
    ed_v = 1'b0; ed_pc = '0; ed_instr = '0; ed_p4 = '0;
  endtask

  // One clock: drive at negedge, sample requests before the edge, check D after it.
  task automatic cyc(input logic st, input logic fl, input logic ps, input logic [31:0] tg,
                     output logic rv, output logic [31:0] ad);
    logic rdy, rspv;
    StallD = st; FlushD = fl; PCSrcE = ps; PCTargetE = tg;
    rdy  = (int'($urandom_range(99)) < rdy_pct);
    rspv = (memq.size() > 0) && (memq[0].due <= cyc_n) && (int'($urandom_range(99)) < rsp_pct);
    mif.imem_req_ready = rdy;
    mif.imem_rsp_valid = rspv;
    mif.imem_rsp_data  = rspv ? mem_word(memq[0].addr) : $urandom();
    #1;
    rv = mif.imem_req_valid; ad = mif.imem_addr;
    if (rv) chk("addr_align", {30'b0, ad[1:0]}, 32'h0);
    if (prev_pend && !ps) begin
      chk("req_hold_valid", 32'(rv), 32'd1);
      chk("req_hold_addr", ad, prev_addr);
    end
    chk("inflight_credit", 32'(memq.size() <= 2), 32'd1);
    prev_pend = rv && !rdy; prev_addr = ad;
    @(posedge clk);
    cyc_n++;
    if (rspv) void'(memq.pop_front());
    if (rv && rdy) memq.push_back('{addr: ad, due: cyc_n + int'($urandom_range(lat_max, lat_min))});
    @(negedge clk);
    if (fl) begin
      chk_bubble("flush");
      ed_v = 1'b0; ed_pc = '0; ed_instr = '0; ed_p4 = '0;
    end else if (st) begin
      chk("hold_v", 32'(ValidD), 32'(ed_v));
      chk("hold_pc", PCD, ed_pc);
      chk("hold_instr", InstrD, ed_instr);
      chk("hold_p4", PCPlus4D, ed_p4);
    end else if (ValidD) begin
      chk("seq_pc", PCD, exp_pc);
      chk("seq_instr", InstrD, mem_word(exp_pc));
      chk("seq_p4", PCPlus4D, exp_pc + 32'd4);
      ed_v = 1'b1; ed_pc = exp_pc; ed_instr = mem_word(exp_pc); ed_p4 = exp_pc + 32'd4;
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end else begin
      chk_bubble("idle");
      ed_v = 1'b0; ed_pc = '0; ed_instr = '0; ed_p4 = '0;
    end
    if (ps) exp_pc = {tg[31:2], 2'b00};
  endtask

  task automatic wait_valid(input int bound, output logic ok);
    logic rv; logic [31:0] ad;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, rv, ad);
      ok = ValidD;
    end
    chk("wait_valid_timeout", 32'(ok), 32'd1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    mif.imem_req_ready = 0; mif.imem_rsp_valid = 0; mif.imem_rsp_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv, ok, found;
    logic [31:0] ad, tg;
    logic st, fl, ps;
    int r;

    tbl = '{
      '{0,0,0,32'h0,   1,32'h00, 0,32'h00,32'h00},
      '{0,0,0,32'h0,   1,32'h04, 1,32'h00,32'h13},
      '{0,0,0,32'h0,   1,32'h08, 1,32'h04,32'h17},
      '{0,0,0,32'h0,   1,32'h0c, 1,32'h08,32'h1b},
      '{1,0,0,32'h0,   1,32'h10, 1,32'h08,32'h1b},
      '{1,0,0,32'h0,   0,32'h00, 1,32'h08,32'h1b},
      '{1,0,0,32'h0,   0,32'h00, 1,32'h08,32'h1b},
      '{0,0,0,32'h0,   0,32'h00, 1,32'h0c,32'h1f},
      '{0,0,0,32'h0,   1,32'h14, 1,32'h10,32'h03},
      '{0,0,0,32'h0,   1,32'h18, 1,32'h14,32'h07},
      '{0,0,0,32'h0,   1,32'h1c, 1,32'h18,32'h0b},
      '{0,1,1,32'h102, 0,32'h00, 0,32'h00,32'h00},
      '{0,0,0,32'h0,   1,32'h100,0,32'h00,32'h00},
      '{0,0,0,32'h0,   1,32'h104,1,32'h100,32'h113},
      '{0,0,0,32'h0,   1,32'h108,1,32'h104,32'h117}
    };

    reset_n = 1'b1;
    StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    mif.imem_req_ready = 0; mif.imem_rsp_valid = 0; mif.imem_rsp_data = '0;
    #1 reset_n = 1'b0;
    #1;
    chk_bubble("reset");
    chk("reset_req_valid", 32'(mif.imem_req_valid), 32'd0);
    apply_reset();

    // Directed stream: 1-cycle memory, stall, redirect.
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].st, tbl[i].fl, tbl[i].ps, tbl[i].tg, rv, ad);
      chk($sformatf("vec%0d_req", i), 32'(rv), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), ad, tbl[i].addr);
      chk($sformatf("vec%0d_v", i), 32'(ValidD), 32'(tbl[i].v));
      chk($sformatf("vec%0d_pc", i), PCD, tbl[i].pc);
      chk($sformatf("vec%0d_instr", i), InstrD, tbl[i].instr);
      chk($sformatf("vec%0d_p4", i), PCPlus4D, tbl[i].v ? tbl[i].pc + 32'd4 : 32'h0);
    end

    // Fill the buffer, then pull reset asynchronously.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0, rv, ad);
    chk("full_credit_req", 32'(rv), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk_bubble("async_reset");
    chk("async_reset_req", 32'(mif.imem_req_valid), 32'd0);
    apply_reset();

    // Memory not ready for 5 cycles.
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, rv, ad);
      chk("nordy_req", 32'(rv), 32'd1);
      chk("nordy_addr", ad, 32'h0);
      chk("nordy_valid", 32'(ValidD), 32'd0);
    end
    rdy_pct = 100;
    wait_valid(10, ok);
    chk("after_reset_pc", PCD, 32'h0);

    // Redirect with two requests in flight and no response in the redirect cycle.
    lat_min = 2; lat_max = 2; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (memq.size() == 2 && memq[0].due > cyc_n) begin
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0102, rv, ad);
        chk("redir_req", 32'(rv), 32'd0);
        found = 1'b1;
      end else cyc(1'b0, 1'b0, 1'b0, 32'h0, rv, ad);
    end
    chk("redir_two_outstanding", 32'(found), 32'd1);
    wait_valid(20, ok);
    chk("redir_first_pc", PCD, 32'h100);
    chk("redir_first_instr", InstrD, 32'h113);

    // PC wrap at the top of the address space.
    lat_min = 0; lat_max = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, rv, ad);
    wait_valid(20, ok);
    chk("wrap_pc", PCD, 32'hFFFF_FFFC);
    chk("wrap_p4", PCPlus4D, 32'h0);
    wait_valid(5, ok);
    chk("wrap_next_pc", PCD, 32'h0);
    chk("wrap_next_p4", PCPlus4D, 32'h4);

    // Random traffic against the program-order model.
    rdy_pct = 75; rsp_pct = 70; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(99));
      st = (r < 20);
      fl = (r >= 20 && r < 26);
      ps = fl && ($urandom_range(1) == 1);
      tg = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      cyc(st, fl, ps, tg, rv, ad);
    end
    rdy_pct = 100; rsp_pct = 100; lat_min = 0; lat_max = 0;
    wait_valid(30, ok);
    chk("random_progress", 32'(n_deliv > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
